dvi_tmds_encoder: RTL and testbench

//  Three-channel DVI 1.0 TMDS encoder. Sits directly downstream of the 480p display-timing

---
 rtl/dvi_tmds_encoder.sv | 140 ++++++++++++++
 tb/tb_dvi_tmds_encoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_tmds_encoder.sv
// Three-channel DVI TMDS encoder (B=ch0, G=ch1, R=ch2) with a fixed two-stage pipeline:
// stage 1 transition-minimises each byte, stage 2 DC-balances it against a running disparity.
`timescale 1ns/1ps
module dvi_tmds_encoder (
  input  logic       clk_pix,
  input  logic       rst,
  input  logic       de,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [9:0] tmds_ch0,
  output logic [9:0] tmds_ch1,
  output logic [9:0] tmds_ch2
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  typedef struct packed {
    logic [9:0]        sym;
    logic signed [4:0] cnt;
  } stage2_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [8:0] tmds_stage1(input logic [7:0] d);
    logic [3:0] ones;
    logic       use_xnor;
    logic [8:0] q;
    ones     = popcount8(d);
    use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  function automatic stage2_t tmds_stage2(input logic [8:0] qm, input logic [3:0] n1,
                                          input logic signed [4:0] cnt, input logic de_v,
                                          input logic [1:0] c);
    logic signed [5:0] bal;    // N1 - N0 of qm[7:0], i.e. 2*N1 - 8
    logic signed [5:0] cnt_w;  // one extra bit so intermediate sums cannot wrap
    stage2_t           res;
    bal     = $signed({1'b0, n1, 1'b0}) - 6'sd8;
    cnt_w   = {cnt[4], cnt};
    res.sym = CTRL_00;
    res.cnt = '0;
    if (!de_v) begin
      unique case (c)
        2'b00: res.sym = CTRL_00;
        2'b01: res.sym = CTRL_01;
        2'b10: res.sym = CTRL_10;
        2'b11: res.sym = CTRL_11;
      endcase
    end else begin
      if ((cnt == 5'sd0) || (bal == 6'sd0)) begin
        res.sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        cnt_w   = qm[8] ? (cnt_w + bal) : (cnt_w - bal);
      end else if ((!cnt[4] && (bal > 6'sd0)) || (cnt[4] && (bal < 6'sd0))) begin
        res.sym = {1'b1, qm[8], ~qm[7:0]};
        cnt_w   = cnt_w - bal + (qm[8] ? 6'sd2 : 6'sd0);
      end else begin
        res.sym = {1'b0, qm[8], qm[7:0]};
        cnt_w   = cnt_w + bal - (qm[8] ? 6'sd0 : 6'sd2);
      end
      res.cnt = cnt_w[4:0];
    end
    return res;
  endfunction

  logic [7:0]        pix    [3];
  logic [8:0]        qm_d   [3];
  logic [8:0]        qm_q   [3];
  logic [3:0]        n1_d   [3];
  logic [3:0]        n1_q   [3];
  logic              de_q;
  logic [1:0]        ctrl_q;
  logic [9:0]        sym_d  [3];
  logic [9:0]        sym_q  [3];
  logic signed [4:0] cnt_d  [3];
  logic signed [4:0] cnt_q  [3];

  assign pix[0] = b;
  assign pix[1] = g;
  assign pix[2] = r;

  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      qm_d[ch] = tmds_stage1(pix[ch]);
      n1_d[ch] = popcount8(qm_d[ch][7:0]);
    end
  end

  // NOTE: every comb output is written on every path through the block, so no latch can form.
  always_comb begin
    stage2_t s2;
    for (int ch = 0; ch < 3; ch++) begin
      s2        = tmds_stage2(qm_q[ch], n1_q[ch], cnt_q[ch], de_q, (ch == 0) ? ctrl_q : 2'b00);
      sym_d[ch] = s2.sym;
      cnt_d[ch] = s2.cnt;
    end
  end

  // NOTE: state updates use <= so every register samples pre-edge values, independent of order.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      de_q   <= 1'b0;
      ctrl_q <= 2'b00;
      for (int ch = 0; ch < 3; ch++) begin
        qm_q[ch]  <= '0;
        n1_q[ch]  <= '0;
        cnt_q[ch] <= '0;
        sym_q[ch] <= CTRL_00;
      end
    end else begin
      de_q   <= de;
      ctrl_q <= {vsync, hsync};
      for (int ch = 0; ch < 3; ch++) begin
        qm_q[ch]  <= qm_d[ch];
        n1_q[ch]  <= n1_d[ch];
        cnt_q[ch] <= cnt_d[ch];
        sym_q[ch] <= sym_d[ch];
      end
    end
  end

  assign tmds_ch0 = sym_q[0];
  assign tmds_ch1 = sym_q[1];
  assign tmds_ch2 = sym_q[2];

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Bench for dvi_tmds_encoder: directed vector table, reset-mid-line sequence, and random
// pixels checked against a behavioural TMDS model plus a symbol decoder.
`timescale 1ns/1ps
module tb_dvi_tmds_encoder;

  localparam logic [9:0] C00 = 10'h354;
  localparam logic [9:0] C01 = 10'h0AB;
  localparam logic [9:0] C10 = 10'h154;
  localparam logic [9:0] C11 = 10'h2AB;

  logic       clk_pix = 1'b0;
  logic       rst, de, hsync, vsync;
  logic [7:0] r, g, b;
  logic [9:0] tmds_ch0, tmds_ch1, tmds_ch2;

  dvi_tmds_encoder dut (
    .clk_pix (clk_pix),
    .rst     (rst),
    .de      (de),
    .hsync   (hsync),
    .vsync   (vsync),
    .r       (r),
    .g       (g),
    .b       (b),
    .tmds_ch0(tmds_ch0),
    .tmds_ch1(tmds_ch1),
    .tmds_ch2(tmds_ch2)
  );

  always #5 clk_pix = ~clk_pix;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: running disparity, symbol in flight, symbol now due at the outputs.
  int         disp    [3];
  logic [9:0] pend    [3];
  logic [9:0] exp_out [3];
  bit         last_de, src_de;
  logic [7:0] last_px [3];
  logic [7:0] src_px  [3];

  typedef struct {
    bit         rst_v, de_v, hs_v, vs_v;
    logic [7:0] px;
    logic [9:0] e0, e12;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic model_sym(input int ch, input bit de_v, input bit [1:0] c,
                           input logic [7:0] d, output logic [9:0] sym);
    logic [8:0] qm;
    int         ones, n1, n0;
    bit         xnor_m;
    if (!de_v) begin
      disp[ch] = 0;
      case (c)
        2'b00: sym = C00;
        2'b01: sym = C01;
        2'b10: sym = C10;
        default: sym = C11;
      endcase
    end else begin
      ones   = $countones(d);
      xnor_m = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      qm[0]  = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xnor_m ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8]  = ~xnor_m;
      n1     = $countones(qm[7:0]);
      n0     = 8 - n1;
      if (disp[ch] == 0 || n1 == n0) begin
        sym      = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        disp[ch] += qm[8] ? (n1 - n0) : (n0 - n1);
      end else if ((disp[ch] > 0 && n1 > n0) || (disp[ch] < 0 && n0 > n1)) begin
        sym      = {1'b1, qm[8], ~qm[7:0]};
        disp[ch] += 2 * int'(qm[8]) + (n0 - n1);
      end else begin
        sym      = {1'b0, qm[8], qm[7:0]};
        disp[ch] += (n1 - n0) - 2 * int'(!qm[8]);
      end
    end
  endtask

  function automatic logic [7:0] tmds_decode(input logic [9:0] s);
    logic [7:0] d, o;
    d    = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  // One clock: drive at the falling edge, let the DUT sample, advance the model, return at the next falling edge.
  task automatic step(input bit rst_v, input bit de_v, input bit hs_v, input bit vs_v,
                      input logic [7:0] r_v, input logic [7:0] g_v, input logic [7:0] b_v);
    logic [7:0] px [3];
    rst = rst_v; de = de_v; hsync = hs_v; vsync = vs_v;
    r = r_v; g = g_v; b = b_v;
    px = '{b_v, g_v, r_v};
    @(posedge clk_pix);
    if (rst_v) begin
      for (int ch = 0; ch < 3; ch++) begin
        exp_out[ch] = C00; pend[ch] = C00; disp[ch] = 0;
      end
      src_de = 1'b0;
    end else begin
      src_de = last_de;
      src_px = last_px;
      for (int ch = 0; ch < 3; ch++) begin
        exp_out[ch] = pend[ch];
        model_sym(ch, de_v, (ch == 0) ? {vs_v, hs_v} : 2'b00, px[ch], pend[ch]);
      end
    end
    last_de = rst_v ? 1'b0 : de_v;
    last_px = px;
    @(negedge clk_pix);
  endtask

  task automatic check_model(input string tag);
    logic [9:0] act [3];
    act = '{tmds_ch0, tmds_ch1, tmds_ch2};
    for (int ch = 0; ch < 3; ch++) begin
      check($sformatf("%s_ch%0d", tag, ch), act[ch], exp_out[ch]);
      if (src_de) begin
        n_checks++;
        if (tmds_decode(act[ch]) !== src_px[ch]) begin
          n_errors++;
          $display("FAIL %s_dec%0d: got %h, expected %h", tag, ch, tmds_decode(act[ch]), src_px[ch]);
        end
      end
    end
  endtask

  function automatic vec_t mk(bit rst_v, bit de_v, bit hs_v, bit vs_v, logic [7:0] px,
                              logic [9:0] e0, logic [9:0] e12);
    vec_t v;
    v.rst_v = rst_v; v.de_v = de_v; v.hs_v = hs_v; v.vs_v = vs_v;
    v.px = px; v.e0 = e0; v.e12 = e12;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit dv;
    rst = 1'b1; de = 1'b0; hsync = 1'b0; vsync = 1'b0; r = '0; g = '0; b = '0;
    last_de = 1'b0; src_de = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      disp[ch] = 0; pend[ch] = C00; exp_out[ch] = C00; last_px[ch] = '0; src_px[ch] = '0;
    end

    // Each row's expected outputs are the symbols for the previous row's inputs.
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, C00,    C00));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, C00,    C00));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, C00,    C00));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, C00,    C00));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, C00,    C00));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, C01,    C00));
    vecs.push_back(mk(0, 0, 1, 1, 8'h00, C10,    C00));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, C11,    C00));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, C00,    C00));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 10'h100, 10'h100));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 10'h3FF, 10'h3FF));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, C00,    C00));
    vecs.push_back(mk(0, 1, 0, 0, 8'hFF, C00,    C00));
    vecs.push_back(mk(0, 1, 1, 1, 8'hFF, 10'h200, 10'h200));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 10'h0FF, 10'h0FF));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, C00,    C00));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, C00,    C00));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 10'h100, 10'h100));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, C00,    C00));

    @(negedge clk_pix);
    foreach (vecs[i]) begin
      step(vecs[i].rst_v, vecs[i].de_v, vecs[i].hs_v, vecs[i].vs_v, vecs[i].px, vecs[i].px, vecs[i].px);
      check($sformatf("vec%0d_ch0", i), tmds_ch0, vecs[i].e0);
      check($sformatf("vec%0d_ch1", i), tmds_ch1, vecs[i].e12);
      check($sformatf("vec%0d_ch2", i), tmds_ch2, vecs[i].e12);
    end

    // Reset while disparity is -8: pipeline dropped, next data symbol is encoded from cnt=0.
    step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    step(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    step(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    check("rstmid_pre_ch0", tmds_ch0, 10'h100);
    step(1, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    check("rstmid_hold_ch0", tmds_ch0, C00);
    check("rstmid_hold_ch2", tmds_ch2, C00);
    step(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    check("rstmid_flush_ch0", tmds_ch0, C00);
    check("rstmid_flush_ch1", tmds_ch1, C00);
    step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    check("rstmid_first_ch0", tmds_ch0, 10'h100);
    check("rstmid_first_ch1", tmds_ch1, 10'h100);

    // One random active line, then random de/sync traffic to exercise transitions.
    for (int i = 0; i < 640; i++) begin
      step(0, 1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      check_model($sformatf("line%0d", i));
    end
    for (int i = 0; i < 120; i++) begin
      dv = ($urandom_range(0, 3) != 0);
      step(0, dv, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      check_model($sformatf("mix%0d", i));
    end

    // After de drops, disparity must be back at zero: 8'h00 encodes as case (a).
    step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    check_model("drop0");
    step(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    check_model("drop1");
    step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    check("drop_zero_ch0", tmds_ch0, 10'h100);
    check("drop_zero_ch2", tmds_ch2, 10'h100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
